// File: rtl/npu_wbuf_pkg.sv
// rtl/npu_wbuf_pkg.sv - shared defaults, weight type and index-width helper for the ping-pong weight buffer
package npu_wbuf_pkg;

  localparam int DW_DEF  = 8;
  localparam int K_H_DEF = 3;
  localparam int K_W_DEF = 3;

  typedef logic [DW_DEF-1:0] w_t;

  // Column index width; a single-column kernel still needs a 1-bit pointer.
  function automatic int col_w(input int k);
    return (k > 1) ? $clog2(k) : 1;
  endfunction

endpackage

// File: rtl/wbuf_bank.sv
// rtl/wbuf_bank.sv - one K_H x K_W weight bank with a column write port and a combinational column read port
module wbuf_bank
  import npu_wbuf_pkg::*;
#(
  parameter int DW  = DW_DEF,
  parameter int K_H = K_H_DEF,
  parameter int K_W = K_W_DEF,
  parameter int CW  = col_w(K_W)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          we,
  input  logic [CW-1:0] wcol,
  input  logic [DW-1:0] wdata [0:K_H-1],
  input  logic [CW-1:0] rcol,
  output logic [DW-1:0] rdata [0:K_H-1]
);

  logic [DW-1:0] mem [0:K_H-1][0:K_W-1];

  // Zero the whole bank on reset/flush, otherwise write one full column.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      for (int r = 0; r < K_H; r++)
        for (int c = 0; c < K_W; c++)
          mem[r][c] <= '0;
    end else if (we) begin
      for (int r = 0; r < K_H; r++)
        mem[r][wcol] <= wdata[r];
    end
  end

  // Present the selected column, one element per PE lane.
  always_comb begin
    for (int r = 0; r < K_H; r++)
      rdata[r] = mem[r][rcol];
  end

endmodule

// File: rtl/cir_wbuf_pp.sv
// rtl/cir_wbuf_pp.sv - ping-pong circular weight buffer; CIR_WBUF_ROW_MASK_EN adds the row_mask port
module cir_wbuf_pp
  import npu_wbuf_pkg::*;
#(
  parameter int DW  = DW_DEF,
  parameter int K_H = K_H_DEF,
  parameter int K_W = K_W_DEF,
  localparam int CW = col_w(K_W)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data [0:K_H-1],
  input  logic          step,
  input  logic          release_req,
  output logic          out_valid,
  output logic [DW-1:0] out_data [0:K_H-1],
  output logic [CW-1:0] col_idx,
`ifdef CIR_WBUF_ROW_MASK_EN
  input  logic [K_H-1:0] row_mask,
`endif
  output logic          wrap
);

  localparam logic [CW-1:0] LAST_COL = CW'(K_W - 1);

  logic [CW-1:0] wp;
  logic [CW-1:0] rp;
  logic          act;
  logic          shadow_full;
  logic          valid_q;
  logic          wrap_q;

  logic          flush;
  logic          accept;
  logic          swap;
  logic [DW-1:0] rd0 [0:K_H-1];
  logic [DW-1:0] rd1 [0:K_H-1];

  assign flush    = !rst_n || clear;
  assign in_ready = !shadow_full;
  assign accept   = in_valid && !shadow_full;
  // A full shadow is promoted when nothing is live or the consumer lets go this cycle.
  assign swap     = shadow_full && (!valid_q || release_req);

  assign out_valid = valid_q;
  assign col_idx   = rp;
  assign wrap      = wrap_q;

  // Bank 0 is active when act = 0, so writes always go to the other bank.
  wbuf_bank #(.DW(DW), .K_H(K_H), .K_W(K_W), .CW(CW)) u_bank0 (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .we    (accept && act),
    .wcol  (wp),
    .wdata (in_data),
    .rcol  (rp),
    .rdata (rd0)
  );

  wbuf_bank #(.DW(DW), .K_H(K_H), .K_W(K_W), .CW(CW)) u_bank1 (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .we    (accept && !act),
    .wcol  (wp),
    .wdata (in_data),
    .rcol  (rp),
    .rdata (rd1)
  );

  // Shadow fill pointer: the last column of a kernel marks the shadow full.
  always_ff @(posedge clk) begin
    if (flush) begin
      wp          <= '0;
      shadow_full <= 1'b0;
    end else if (swap) begin
      shadow_full <= 1'b0;
    end else if (accept) begin
      if (wp == LAST_COL) begin
        wp          <= '0;
        shadow_full <= 1'b1;
      end else begin
        wp <= wp + 1'b1;
      end
    end
  end

  // Active bank control: swap has priority, then release, then rotation.
  always_ff @(posedge clk) begin
    if (flush) begin
      act     <= 1'b0;
      valid_q <= 1'b0;
      rp      <= '0;
      wrap_q  <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (swap) begin
        act     <= !act;
        valid_q <= 1'b1;
        rp      <= '0;
      end else if (valid_q && release_req) begin
        valid_q <= 1'b0;
        rp      <= '0;
      end else if (valid_q && step) begin
        if (rp == LAST_COL) begin
          rp     <= '0;
          wrap_q <= 1'b1;
        end else begin
          rp <= rp + 1'b1;
        end
      end
    end
  end

  // Drive the active column to the PE row; zero when no kernel is live or the row is masked.
  always_comb begin
    for (int r = 0; r < K_H; r++) begin
      out_data[r] = '0;
      if (valid_q)
        out_data[r] = act ? rd1[r] : rd0[r];
`ifdef CIR_WBUF_ROW_MASK_EN
      if (!row_mask[r])
        out_data[r] = '0;
`endif
    end
  end

endmodule
